// File: rtl/rr_arb_mux_nbit.sv
// N-input round-robin arbitrated mux with one registered output stage and valid/ready on every channel.
// Define RR_ARB_MUX_ZERO_IDLE_EN to force out_data/out_sel to zero whenever the output is idle.
module rr_arb_mux_nbit #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 32,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [SELW:0]   NCNT = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0] r_ptr;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_sel;
    logic            r_out_valid;

    logic [N-1:0]    w_rot;
    logic            w_any;
    logic            w_found;
    logic [SELW-1:0] w_off;
    logic [SELW:0]   w_sum;
    logic [SELW-1:0] w_gnt_idx;
    logic [N-1:0]    w_grant;
    logic [W-1:0]    w_sel_data;
    logic            w_can_load;
    logic            w_xfer;

    logic [SELW-1:0] w_ptr_nxt;
    logic [W-1:0]    w_data_nxt;
    logic [SELW-1:0] w_sel_nxt;
    logic            w_valid_nxt;

    // Rotate requests so bit 0 is the channel at the priority pointer.
    assign w_rot = N'({in_valid, in_valid} >> r_ptr);
    assign w_any = |w_rot;

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = SELW'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gnt_idx = (w_sum >= NCNT) ? SELW'(w_sum - NCNT) : w_sum[SELW-1:0];

    always_comb begin
        w_grant    = '0;
        w_sel_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_grant[i] = w_any && (w_gnt_idx == SELW'(i));
            if (w_grant[i]) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    assign w_can_load = ~r_out_valid | out_ready;
    assign w_xfer     = w_any & w_can_load;
    assign in_ready   = w_grant & {N{w_can_load}};

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_data_nxt  = r_out_data;
        w_sel_nxt   = r_out_sel;
        w_valid_nxt = r_out_valid;
        if (w_xfer) begin
            w_data_nxt  = w_sel_data;
            w_sel_nxt   = w_gnt_idx;
            w_valid_nxt = 1'b1;
            w_ptr_nxt   = (w_gnt_idx == LAST) ? '0 : w_gnt_idx + SELW'(1);
        end else if (out_ready) begin
            w_valid_nxt = 1'b0;
        end
`ifdef RR_ARB_MUX_ZERO_IDLE_EN
        if (!w_valid_nxt) begin
            w_data_nxt = '0;
            w_sel_nxt  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_out_data  <= w_data_nxt;
            r_out_sel   <= w_sel_nxt;
            r_out_valid <= w_valid_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_mux_nbit.sv
// Scoreboard bench for rr_arb_mux_nbit: a 3-channel 32-bit instance and a 1-channel 8-bit instance,
// each checked against a round-robin reference model with queued expected outputs.
module tb_rr_arb_mux_nbit;

    localparam int N = 3;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    logic [7:0] s_in_data;
    logic [0:0] s_in_valid;
    logic [0:0] s_in_ready;
    logic [7:0] s_out_data;
    logic [0:0] s_out_sel;
    logic       s_out_valid;
    logic       s_out_ready;

    rr_arb_mux_nbit #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_arb_mux_nbit #(.N(1), .W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_sel   (s_out_sel),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } item_t;

    int checks = 0;
    int errors = 0;

    item_t      exp_q[$];
    logic [7:0] s_q[$];
    item_t      mon_e;
    logic [7:0] s_mon_e;
    int         s_rcv = 0;

    // Reference model state
    bit          m_occ;
    int          m_ptr;
    logic [31:0] m_idle_data;
    logic [1:0]  m_idle_sel;
    bit          s_occ;
    int          s_nxt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_occ       = 1'b0;
        m_ptr       = 0;
        m_idle_data = '0;
        m_idle_sel  = '0;
        exp_q.delete();
    endtask

    // One cycle on the 3-channel instance: drive, check combinational/held state, advance model.
    task automatic cyc(input logic [2:0] v, input logic rdy, input logic [95:0] d);
        int         g;
        logic       can;
        logic [2:0] er;
        item_t      e;
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        in_data   = d;
        #1;
        can = !m_occ || rdy;
        g   = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && v[c]) g = c;
        end
        er = (g >= 0 && can) ? 3'(1 << g) : 3'b000;
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, m_occ);
        if (!m_occ) begin
            chk("idle_data", out_data, m_idle_data);
            chk("idle_sel", out_sel, m_idle_sel);
        end else if (exp_q.size() > 0) begin
            chk("held_data", out_data, exp_q[0].data);
        end
        if (g >= 0 && can) begin
            e.data = d[g*W +: W];
            e.sel  = 2'(g);
            exp_q.push_back(e);
            m_occ       = 1'b1;
            m_ptr       = (g + 1) % N;
            m_idle_data = e.data;
            m_idle_sel  = e.sel;
        end else if (rdy) begin
            m_occ = 1'b0;
`ifdef RR_ARB_MUX_ZERO_IDLE_EN
            m_idle_data = '0;
            m_idle_sel  = '0;
`endif
        end
    endtask

    // One cycle on the single-channel instance streaming 1..5.
    task automatic scyc(input bit force_rdy);
        logic exp_rdy;
        @(negedge clk);
        s_in_valid  = 1'(s_nxt <= 5);
        s_in_data   = 8'(s_nxt);
        s_out_ready = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        exp_rdy = s_in_valid[0] && (!s_occ || s_out_ready);
        chk("s_in_ready", s_in_ready, exp_rdy);
        chk("s_out_valid", s_out_valid, s_occ);
        if (exp_rdy) begin
            s_q.push_back(8'(s_nxt));
            s_nxt++;
            s_occ = 1'b1;
        end else if (s_out_ready) begin
            s_occ = 1'b0;
        end
    endtask

    // Monitors: an item leaves on the edge where out_valid && out_ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_extra", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_sel", out_sel, mon_e.sel);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    chk("s_out_extra", s_out_valid, 1'b0);
                end else begin
                    s_mon_e = s_q.pop_front();
                    s_rcv++;
                    chk("s_out_data", s_out_data, s_mon_e);
                    chk("s_out_sel", s_out_sel, 1'b0);
                end
            end
        end
    end

    initial begin
        logic [95:0] abc;
        abc         = {32'h33, 32'h22, 32'h11};
        rst_n       = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        s_in_valid  = '0;
        s_in_data   = '0;
        s_out_ready = 1'b0;
        s_occ       = 1'b0;
        s_nxt       = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_sel", out_sel, 2'd0);
        chk("rst_in_ready", in_ready, 3'b000);
        #3 rst_n = 1'b1;

        // Round-robin with all channels requesting
        repeat (6) cyc(3'b111, 1'b1, abc);
        // Backpressure on 0x22, then channel 2 next
        cyc(3'b111, 1'b1, abc);
        cyc(3'b111, 1'b1, abc);
        repeat (4) cyc(3'b111, 1'b0, abc);
        cyc(3'b111, 1'b1, abc);
        // Pointer wrap and skip
        cyc(3'b111, 1'b1, abc);
        cyc(3'b111, 1'b1, abc);
        cyc(3'b011, 1'b1, abc);
        cyc(3'b011, 1'b1, abc);
        // Idle drain
        cyc(3'b010, 1'b1, {32'h0, 32'hDEADBEEF, 32'h0});
        repeat (3) cyc(3'b000, 1'b1, '0);

        // Reset while an item is held
        cyc(3'b111, 1'b1, abc);
        cyc(3'b000, 1'b0, '0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 32'h0);
        chk("midrst_out_sel", out_sel, 2'd0);
        model_reset();
        @(negedge clk);
        #3 rst_n = 1'b1;
        cyc(3'b111, 1'b1, abc);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                {$urandom(), $urandom(), $urandom()});
        end
        repeat (4) cyc(3'b000, 1'b1, '0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // Single-channel instance
        for (int i = 0; i < 60; i++) scyc(1'b0);
        repeat (8) scyc(1'b1);
        chk("s_sent", 64'(s_nxt), 64'd6);
        chk("s_rcvd", 64'(s_rcv), 64'd5);
        chk("s_queue_empty", 64'(s_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux_nbit.md
Name: rr_arb_mux_nbit

Overview:
- N-input, W-bit registered multiplexer with a round-robin arbiter and valid/ready handshakes on every channel.
- Successor to the fixed-select 3-input mux: the select is generated internally from channel requests, and the result is registered.
- Used where several pipeline producers share one consumer, e.g. IF/MEM requests onto a single memory port or multiple writeback sources.
- Single output register stage; 1-cycle latency; sustains 1 transfer per cycle.

Parameters:
- N, 3, number of input channels (1 to 16).
- W, 32, data width per channel.
- SELW (localparam, derived, not overridable): max(1, clog2(N)).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_data  output  W  registered selected data.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel hold a transfer.
- out_ready  input  1  consumer accepts the output this cycle.

Behaviour:
- Reset (async assert, sync-released by system): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready is combinational and is therefore 0 while out_valid=0 with no in_valid.
- can_load = ~out_valid | out_ready.
- Grant (combinational): search channels ptr, ptr+1, …, N-1, 0, …, ptr-1; grant[g] for the first channel with in_valid set; no grant if in_valid==0.
- in_ready[i] = grant[i] & can_load. in_ready must not depend on out_data.
- Transfer on channel g when in_valid[g] & in_ready[g]. Next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=(g==N-1)?0:g+1.
- No transfer and out_ready=1: out_valid<=0; out_data/out_sel per Optional Feature.
- out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold; all in_ready=0; ptr holds.
- Simultaneous drain and load (out_valid=1, out_ready=1, request present): new item loaded, out_valid stays 1, no bubble.
- Fairness: a channel holding in_valid is granted within N transfers.
- ptr updates only on a transfer, never on idle or stall cycles.
- N=1: ptr is constant 0, out_sel is constant 0, and the block degenerates to a single-entry pipeline register.
- in_valid deasserted before acceptance: legal; the block imposes no stickiness.
- Reset mid-transfer: the held item is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro: RR_ARB_MUX_ZERO_IDLE_EN.
- Defined: whenever out_valid will be 0 after the edge, out_data<=0 and out_sel<=0, so the idle output is all zeros, as with the mux default case.
- Undefined: out_data/out_sel keep their last value while idle; the saved register enables are permitted.
- The handshake and arbitration are identical in both builds.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 asynchronously; after release, first grant goes to channel 0 when in_valid=3'b111.
- Round-robin: N=3, in_valid=3'b111 held, out_ready=1, data A/B/C = 0x11/0x22/0x33 -> out_sel sequence 0,1,2,0,1,2 and out_data 0x11,0x22,0x33,…; out_valid stays 1 every cycle after the first.
- Backpressure: out_valid=1 with 0x22, out_ready=0 for 4 cycles -> out_data stays 0x22, in_ready=3'b000, ptr unchanged; out_ready=1 -> channel 2 granted next.
- Pointer wrap/skip: ptr=2, in_valid=3'b011 -> channel 0 granted, ptr becomes 1; next request 3'b011 -> channel 1.
- Idle drain: single request ch1=0xDEADBEEF then in_valid=0, out_ready=1 -> out_valid drops one cycle later; out_data=0 with RR_ARB_MUX_ZERO_IDLE_EN, 0xDEADBEEF without.
- N=1 build, W=8: stream 0x01..0x05 with random out_ready -> outputs in order, no loss or duplication, out_sel always 0.
